// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath with a memory handshake, wait
// watchdog and illegal-opcode flagging. Outputs decode from the current state.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 on mem_ready
// DECODE    | latch opcode, branch target into ALUOut
// MEM_ADDR  | effective address for lw/sw
// MEM_READ  | data read at ALUOut
// MEM_WB    | MDR into rt
// MEM_WRITE | data write at ALUOut
// R_EXEC    | R-type ALU operation
// R_WB      | ALUOut into rd
// I_EXEC    | immediate ALU operation
// I_WB      | ALUOut into rt
// BRANCH    | compare, conditional PC load from ALUOut
// JUMP      | PC <= jump target
// JAL       | PC <= jump target, $31 <= PC
module multicycle_control #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_ne,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_state;
  logic       timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'd0;
      wait_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    mem_req          = 1'b0;
    mem_write        = 1'b0;
    i_or_d           = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    pc_source        = 2'b00;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = 3'b000;
    reg_dst          = 2'b00;
    mem_to_reg       = 2'b00;
    reg_write        = 1'b0;
    illegal_op       = 1'b0;
    bus_error        = 1'b0;
    state_o          = state_q;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    // a ready arriving on the final allowed cycle still wins over the timeout
    timeout   = mem_state && !mem_ready && (wait_q == 8'(MAX_WAIT));
    wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;

    case (state_q)
      S_FETCH: begin
        mem_req   = !timeout;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        opcode_d  = opcode;
        case (opcode)
          6'd0:                                  state_d = S_R_EXEC;
          6'd35, 6'd43:                          state_d = S_MEM_ADDR;
          6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: state_d = S_I_EXEC;
          6'd4, 6'd5:                            state_d = S_BRANCH;
          6'd2:                                  state_d = S_JUMP;
          6'd3:                                  state_d = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode_q == 6'd35) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = !timeout;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req   = !timeout;
        mem_write = !timeout;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode_q)
          6'd10:   alu_op = 3'b101;
          6'd12:   alu_op = 3'b011;
          6'd13:   alu_op = 3'b100;
          6'd14:   alu_op = 3'b110;
          6'd15:   alu_op = 3'b111;
          default: alu_op = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        alu_op           = 3'b001;
        pc_source        = 2'b01;
        pc_write_cond    = (opcode_q == 6'd4);
        pc_write_cond_ne = (opcode_q == 6'd5);
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      bus_error = 1'b1;
      state_d   = S_FETCH;
    end

    // reset silences every output immediately so an in-flight access cannot complete
    if (reset) begin
      mem_req          = 1'b0;
      mem_write        = 1'b0;
      i_or_d           = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      pc_source        = 2'b00;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      alu_op           = 3'b000;
      reg_dst          = 2'b00;
      mem_to_reg       = 2'b00;
      reg_write        = 1'b0;
      illegal_op       = 1'b0;
      bus_error        = 1'b0;
      state_o          = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each issued instruction pushes an expected per-instruction
// summary; a monitor rebuilds the same summary from the DUT outputs and compares.
module tb_multicycle_control;
  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic       pc_write_cond, pc_write_cond_ne;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op, bus_error;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic [25:0] all_out;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_write_cond_ne(pc_write_cond_ne), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .bus_error(bus_error), .state_o(state_o)
  );

  assign all_out = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                    pc_write_cond_ne, pc_source, alu_src_a, alu_src_b, alu_op,
                    reg_dst, mem_to_reg, reg_write, illegal_op, bus_error, state_o};

  typedef struct packed {
    int cycles, n_req, n_req_d, n_memw, n_wdone, n_ir, n_pcw, n_regw, regw;
    int n_ill, n_bus, n_cond, n_cond_ne, alu, pcsrc;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string fmt(rec_t r);
    return $sformatf("cyc=%0d req=%0d reqd=%0d memw=%0d wdone=%0d ir=%0d pcw=%0d rw=%0d rwsel=%0d ill=%0d bus=%0d beq=%0d bne=%0d alu=%0d pcsrc=%0d",
                     r.cycles, r.n_req, r.n_req_d, r.n_memw, r.n_wdone, r.n_ir, r.n_pcw,
                     r.n_regw, r.regw, r.n_ill, r.n_bus, r.n_cond, r.n_cond_ne, r.alu, r.pcsrc);
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'd0, 6'd35, 6'd43, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15,
                      6'd4, 6'd5, 6'd2, 6'd3};
  endfunction

  function automatic int imm_alu(logic [5:0] op);
    case (op)
      6'd10:   return 5;
      6'd12:   return 3;
      6'd13:   return 4;
      6'd14:   return 6;
      6'd15:   return 7;
      default: return 0;
    endcase
  endfunction

  // Instruction-level reference: fw/mw are the wait cycles before mem_ready
  // in fetch and in the data access; a wait beyond MW is a bus error.
  function automatic rec_t model(logic [5:0] op, int fw, int mw);
    rec_t e;
    int   mlen;
    bit   mto;
    e = '0;
    e.regw = -1; e.alu = -1; e.pcsrc = -1;
    if (fw > MW) begin
      e.cycles = MW + 1; e.n_req = MW; e.n_bus = 1;
      return e;
    end
    e.cycles = fw + 2;
    e.n_req = fw + 1; e.n_ir = 1; e.n_pcw = 1; e.pcsrc = 0;
    mto  = (mw > MW);
    mlen = mto ? MW + 1 : mw + 1;
    if (op == 6'd0) begin
      e.cycles += 2; e.n_regw = 1; e.regw = 4; e.alu = 2;
    end else if (op inside {6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15}) begin
      e.cycles += 2; e.n_regw = 1; e.regw = 0; e.alu = imm_alu(op);
    end else if (op == 6'd35 || op == 6'd43) begin
      e.cycles += 1 + mlen; e.alu = 0;
      e.n_req += mto ? MW : mlen;
      e.n_req_d = mto ? MW : mlen;
      if (op == 6'd43) e.n_memw = mto ? MW : mlen;
      if (mto) e.n_bus = 1;
      else if (op == 6'd35) begin e.cycles += 1; e.n_regw = 1; e.regw = 1; end
      else e.n_wdone = 1;
    end else if (op == 6'd4 || op == 6'd5) begin
      e.cycles += 1; e.alu = 1; e.pcsrc = 1;
      if (op == 6'd4) e.n_cond = 1; else e.n_cond_ne = 1;
    end else if (op == 6'd2) begin
      e.cycles += 1; e.n_pcw = 2; e.pcsrc = 2;
    end else if (op == 6'd3) begin
      e.cycles += 1; e.n_pcw = 2; e.pcsrc = 2; e.n_regw = 1; e.regw = 10;
    end else begin
      e.n_ill = 1;
    end
    return e;
  endfunction

  // monitor: an instruction begins at a FETCH cycle entered from another state,
  // from reset, or right after a bus error
  initial begin
    rec_t cur, e;
    bit   active, prev_rst, prev_bus;
    logic [3:0] prev_st;
    int   txn;
    active = 0; prev_rst = 1; prev_bus = 0; prev_st = 4'd0; txn = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0; prev_rst = 1;
        continue;
      end
      if (state_o == 4'd0 && (prev_rst || prev_st != 4'd0 || prev_bus)) begin
        if (active) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL txn %0d unexpected: got %s", txn, fmt(cur));
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              errors++;
              $display("FAIL txn %0d: got %s | exp %s", txn, fmt(cur), fmt(e));
            end
          end
          txn++;
        end
        cur = '0; cur.regw = -1; cur.alu = -1; cur.pcsrc = -1;
        active = 1;
      end
      if (active) begin
        cur.cycles++;
        if (mem_req) cur.n_req++;
        if (mem_req && i_or_d) cur.n_req_d++;
        if (mem_write) cur.n_memw++;
        if (mem_req && mem_write && mem_ready) cur.n_wdone++;
        if (ir_write) cur.n_ir++;
        if (pc_write) cur.n_pcw++;
        if (reg_write) begin
          cur.n_regw++;
          cur.regw = int'(reg_dst) * 4 + int'(mem_to_reg);
        end
        if (illegal_op) cur.n_ill++;
        if (bus_error) cur.n_bus++;
        if (pc_write_cond) cur.n_cond++;
        if (pc_write_cond_ne) cur.n_cond_ne++;
        if (alu_src_a) cur.alu = int'(alu_op);
        if (pc_write || pc_write_cond || pc_write_cond_ne) cur.pcsrc = int'(pc_source);
      end
      prev_st = state_o; prev_bus = bus_error; prev_rst = 0;
    end
  end

  // Drives one instruction. abort_at >= 0 raises reset in that cycle instead
  // of completing; check_first checks the first cycle after a reset release.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int abort_at, input bit check_first);
    rec_t e;
    int   flen, ms, mlen;
    bit   mem_op;
    e      = model(op, fw, mw);
    flen   = (fw > MW) ? MW + 1 : fw + 1;
    mem_op = (fw <= MW) && (op == 6'd35 || op == 6'd43);
    ms     = flen + 2;
    mlen   = (mw > MW) ? MW + 1 : mw + 1;
    if (abort_at < 0) exp_q.push_back(e);
    for (int k = 0; k < e.cycles; k++) begin
      opcode = (k == flen) ? op : 6'($urandom);
      if (k < flen) mem_ready = (k == fw);
      else if (mem_op && k >= ms && k < ms + mlen) mem_ready = (k - ms == mw);
      else mem_ready = 1'($urandom);
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out != 26'd0) begin
          errors++;
          $display("FAIL abort_outputs op=%0d: got %h exp 0", op, all_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (k == 0 && check_first) begin
        @(negedge clk);
        checks++;
        if (state_o != 4'd0 || !mem_req) begin
          errors++;
          $display("FAIL post_reset_fetch: got state=%0d req=%0d exp state=0 req=1", state_o, mem_req);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] legal [13];
    logic [5:0] op;
    int r;
    legal = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15,
              6'd4, 6'd5, 6'd2, 6'd3};
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (all_out != 26'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %h exp 0", all_out);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'd0,  0, 0, -1, 1);
    run_instr(6'd35, 0, 0, -1, 0);
    run_instr(6'd43, 0, 0, -1, 0);
    run_instr(6'd4,  0, 0, -1, 0);
    run_instr(6'd2,  0, 0, -1, 0);
    run_instr(6'd3,  0, 0, -1, 0);
    run_instr(6'd35, 3, 3, -1, 0);
    run_instr(6'd43, 0, 99, -1, 0);
    run_instr(6'h3F, 0, 0, -1, 0);
    run_instr(6'd0,  0, 0, -1, 0);
    run_instr(6'd35, 0, 10, 4, 0);
    run_instr(6'd3,  1, 0, 3, 1);
    run_instr(6'd5,  2, 0, -1, 1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 15);
      if (r < 13) op = legal[r];
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0,
                $urandom_range(0, 6), -1, 0);
    end

    mem_ready = 1'b0; opcode = 6'd0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_txns: got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
